// File: rtl/grant_bus_mux_if.sv
// Bundle between arbiter-side masters, the grant mux and the shared slave.
// The mux uses the slave modport; the driving environment uses master.
interface grant_bus_mux_if #(
  parameter int AW   = 8,
  parameter int DW   = 16,
  parameter int CNTW = 8
);
  logic [3:0]      gnt;
  logic [3:0]      m_valid;
  logic [3:0]      m_we;
  logic [4*AW-1:0] m_addr;
  logic [4*DW-1:0] m_wdata;
  logic [3:0]      m_ack;
  logic [3:0]      m_err;
  logic [DW-1:0]   m_rdata;
  logic            s_valid;
  logic            s_we;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic            s_ready;
  logic [DW-1:0]   s_rdata;
  logic            gnt_err;
  logic            busy;
  logic [4*CNTW-1:0] txn_cnt;

  modport master (
    output gnt, m_valid, m_we, m_addr, m_wdata,
    output s_ready, s_rdata,
    input  m_ack, m_err, m_rdata,
    input  s_valid, s_we, s_addr, s_wdata,
    input  gnt_err, busy, txn_cnt
  );

  modport slave (
    input  gnt, m_valid, m_we, m_addr, m_wdata,
    input  s_ready, s_rdata,
    output m_ack, m_err, m_rdata,
    output s_valid, s_we, s_addr, s_wdata,
    output gnt_err, busy, txn_cnt
  );
endinterface

// File: rtl/grant_bus_mux.sv
// Routes the one-hot granted master's command to a shared slave and
// returns ack/err with read data; adds timeout, grant check, counters.
module grant_bus_mux #(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15,
  parameter int CNTW    = 8
) (
  input logic          clk,
  input logic          rst,
  grant_bus_mux_if.slave bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   LAST = TW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t        state;
  logic [1:0]    sel;
  logic [TW-1:0] tcnt;

  logic          one_hot;
  logic          multi;
  logic [1:0]    idx;
  logic [CNTW-1:0] cur_cnt;

  always_comb begin
    idx     = 2'd0;
    multi   = (bus.gnt & (bus.gnt - 4'd1)) != 4'd0;
    one_hot = (bus.gnt != 4'd0) && !multi;
    if (one_hot) begin
      unique case (1'b1)
        bus.gnt[0]: idx = 2'd0;
        bus.gnt[1]: idx = 2'd1;
        bus.gnt[2]: idx = 2'd2;
        bus.gnt[3]: idx = 2'd3;
        default:    idx = 2'd0;
      endcase
    end
  end

  assign cur_cnt = bus.txn_cnt[sel*CNTW +: CNTW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= 2'd0;
      tcnt        <= '0;
      bus.s_valid <= 1'b0;
      bus.s_we    <= 1'b0;
      bus.s_addr  <= '0;
      bus.s_wdata <= '0;
      bus.m_ack   <= 4'd0;
      bus.m_err   <= 4'd0;
      bus.m_rdata <= '0;
      bus.gnt_err <= 1'b0;
      bus.busy    <= 1'b0;
      bus.txn_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (multi) begin
            bus.gnt_err <= 1'b1;
          end else if (one_hot && bus.m_valid[idx]) begin
            sel         <= idx;
            tcnt        <= '0;
            bus.s_valid <= 1'b1;
            bus.s_we    <= bus.m_we[idx];
            bus.s_addr  <= bus.m_addr[idx*AW +: AW];
            bus.s_wdata <= bus.m_wdata[idx*DW +: DW];
            bus.busy    <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          // s_ready on the limit cycle still completes normally
          if (bus.s_ready) begin
            bus.s_valid    <= 1'b0;
            bus.s_we       <= 1'b0;
            bus.s_addr     <= '0;
            bus.s_wdata    <= '0;
            bus.m_rdata    <= bus.s_we ? '0 : bus.s_rdata;
            bus.m_ack[sel] <= 1'b1;
            if (cur_cnt != CMAX) begin
              bus.txn_cnt[sel*CNTW +: CNTW] <= cur_cnt + 1'b1;
            end
            state <= DONE;
          end else if (tcnt == LAST) begin
            bus.s_valid    <= 1'b0;
            bus.s_we       <= 1'b0;
            bus.s_addr     <= '0;
            bus.s_wdata    <= '0;
            bus.m_rdata    <= '0;
            bus.m_err[sel] <= 1'b1;
            state          <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          bus.m_ack   <= 4'd0;
          bus.m_err   <= 4'd0;
          bus.m_rdata <= '0;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grant_bus_mux.sv
// Scoreboard bench for grant_bus_mux: randomized transactions against
// a transaction-level model; a negedge monitor checks completions.
module tb_grant_bus_mux;
  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int TO   = 15;
  localparam int CNTW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  grant_bus_mux_if #(.AW(AW), .DW(DW), .CNTW(CNTW)) bus ();

  grant_bus_mux #(
    .AW(AW), .DW(DW), .TIMEOUT(TO), .CNTW(CNTW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int            m;
    bit            err;
    logic [DW-1:0] rdata;
    int            cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   model_cnt[4];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // expected completion for one transaction from its slave latency
  task automatic model(int i, bit we, int lat, logic [DW-1:0] rd);
    exp_t e;
    e.m     = i;
    e.err   = (lat >= TO);
    e.rdata = (e.err || we) ? '0 : rd;
    if (!e.err && model_cnt[i] < (1 << CNTW) - 1) model_cnt[i]++;
    e.cnt = model_cnt[i];
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_ack != 4'd0 || bus.m_err != 4'd0) begin
        chk("ack_err_legal",
            ((bus.m_ack & bus.m_err) == 4'd0) &&
            $onehot0(bus.m_ack) && $onehot0(bus.m_err), 1);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("m_ack", bus.m_ack, mon_e.err ? 0 : (1 << mon_e.m));
          chk("m_err", bus.m_err, mon_e.err ? (1 << mon_e.m) : 0);
          chk("m_rdata", bus.m_rdata, mon_e.rdata);
          chk("txn_cnt", bus.txn_cnt[mon_e.m*CNTW +: CNTW], mon_e.cnt);
        end
      end else begin
        chk("rdata_quiet", bus.m_rdata, 0);
      end
    end
  end

  task automatic txn(int i, bit we, logic [AW-1:0] a,
                     logic [DW-1:0] wd, int lat,
                     logic [DW-1:0] rd, int mv);
    int n;
    int expn;
    model(i, we, lat, rd);
    bus.gnt     = 4'd1 << i;
    bus.m_valid = 4'd1 << i;
    bus.m_we[i] = we;
    bus.m_addr[i*AW +: AW]  = a;
    bus.m_wdata[i*DW +: DW] = wd;
    @(posedge clk); #1;
    chk("s_valid_issue", bus.s_valid, 1);
    chk("busy_issue", bus.busy, 1);
    n    = 0;
    expn = (lat < TO) ? lat + 1 : TO;
    while (bus.s_valid && n < 40) begin
      if (n == 1 && mv >= 0) bus.gnt = 4'd1 << mv;
      chk("s_addr", bus.s_addr, a);
      chk("s_we", bus.s_we, we);
      chk("s_wdata", bus.s_wdata, wd);
      bus.s_ready = (n == lat);
      bus.s_rdata = rd;
      n++;
      @(posedge clk); #1;
    end
    bus.s_ready = 1'b0;
    bus.s_rdata = DW'($urandom);
    chk("issue_cycles", n, expn);
    chk("busy_done", bus.busy, 1);
    bus.m_valid = 4'd0;
    bus.gnt     = 4'd0;
    @(posedge clk); #1;
    chk("busy_idle", bus.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 4; k++) model_cnt[k] = 0;
    rst         = 1'b1;
    bus.gnt     = 4'd0;
    bus.m_valid = 4'd0;
    bus.m_we    = 4'd0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.s_ready = 1'b0;
    bus.s_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_valid", bus.s_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_txn_cnt", bus.txn_cnt, 0);
    chk("rst_gnt_err", bus.gnt_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    txn(0, 1'b0, 8'h3C, 16'h0000, 0, 16'hBEEF, -1);
    txn(2, 1'b1, 8'h10, 16'h1234, 99, 16'h5555, -1);
    txn(1, 1'b0, 8'h77, 16'h0000, 14, 16'hA5A5, 3);

    for (int k = 0; k < 60; k++) begin
      txn($urandom_range(0, 3), 1'($urandom), AW'($urandom),
          DW'($urandom), $urandom_range(0, TO + 2),
          DW'($urandom),
          $urandom_range(0, 1) ? $urandom_range(0, 3) : -1);
    end

    // reset in the middle of an issue drops the transaction
    bus.gnt     = 4'b0001;
    bus.m_valid = 4'b0001;
    @(posedge clk); #1;
    chk("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_s_valid", bus.s_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_m_ack", bus.m_ack, 0);
    chk("mid_rst_txn_cnt", bus.txn_cnt, 0);
    bus.gnt     = 4'd0;
    bus.m_valid = 4'd0;
    sb.delete();
    for (int k = 0; k < 4; k++) model_cnt[k] = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_s_valid", bus.s_valid, 0);

    txn(0, 1'b0, 8'h3C, 16'h0000, 0, 16'hBEEF, -1);
    chk("gnt_err_clear", bus.gnt_err, 0);

    bus.gnt     = 4'b0110;
    bus.m_valid = 4'b0110;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("multi_s_valid", bus.s_valid, 0);
      chk("multi_busy", bus.busy, 0);
    end
    chk("gnt_err_set", bus.gnt_err, 1);
    bus.gnt     = 4'd0;
    bus.m_valid = 4'd0;
    @(posedge clk); #1;

    for (int k = 0; k < 300; k++) begin
      txn(3, 1'b0, AW'($urandom), '0, 0, DW'($urandom), -1);
    end
    chk("sat_cnt3", bus.txn_cnt[3*CNTW +: CNTW], 255);
    chk("gnt_err_sticky", bus.gnt_err, 1);
    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
